// File: rtl/dds_pkg.sv
// Shared DDS definitions: default table/accumulator widths used by both the
// phase reader and the waveform table RAM, plus the FTW apply-cause encoding.
package dds_pkg;

    // Default widths; the table RAM is instantiated with the same values.
    localparam int unsigned DEF_PHASE_WIDTH = 24;
    localparam int unsigned DEF_ADDR_WIDTH  = 8;
    localparam int unsigned DEF_DATA_WIDTH  = 6;

    // Why a pending tuning word is being moved into the live FTW register.
    typedef enum logic [1:0] {
        ApplyNone,  // nothing pending, or waiting for a wrap
        ApplyWrap,  // running and the accumulator carried out
        ApplyIdle,  // accumulator stalled (EN low)
        ApplyClr    // synchronous phase clear
    } apply_e;

endpackage

// File: rtl/dds_phase_acc.sv
// Phase accumulator with carry/WRAP pulse and a one-deep FTW holding register.
// New tuning words are only committed at a phase-continuous point: on the
// wrap edge, while the accumulator is stalled, or on a synchronous clear.
module dds_phase_acc
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic                   SYNC_CLR,
    input  logic [PHASE_WIDTH-1:0] FTW_IN,
    input  logic                   FTW_VALID,
    output logic                   FTW_READY,
    output logic [ADDR_WIDTH-1:0]  PHASE_ADDR,
    output logic                   WRAP
);

    logic [PHASE_WIDTH-1:0] acc_q, acc_d;
    logic [PHASE_WIDTH-1:0] ftw_q, ftw_d;
    logic [PHASE_WIDTH-1:0] pend_ftw_q, pend_ftw_d;
    logic                   pending_q, pending_d;
    logic                   wrap_q, wrap_d;

    logic [PHASE_WIDTH:0]   sum;
    logic                   carry;
    logic                   accept;
    apply_e                 apply_cause;

    // Adder with explicit carry-out; the add always uses the live ftw_q.
    always_comb begin
        sum   = {1'b0, acc_q} + {1'b0, ftw_q};
        carry = sum[PHASE_WIDTH];
    end

    // Handshake acceptance: the holding register must be empty. Accept and
    // apply are mutually exclusive since apply requires pending_q.
    always_comb begin
        accept = FTW_VALID && !pending_q;
    end

    // Decide whether (and why) a held FTW commits on this edge.
    always_comb begin
        apply_cause = ApplyNone;
        if (pending_q) begin
            if (SYNC_CLR) begin
                apply_cause = ApplyClr;
            end else if (!EN) begin
                apply_cause = ApplyIdle;
            end else if (carry) begin
                apply_cause = ApplyWrap;
            end
        end
    end

    // Next-state for accumulator, WRAP and the FTW registers.
    always_comb begin
        acc_d      = acc_q;
        wrap_d     = 1'b0;
        ftw_d      = ftw_q;
        pend_ftw_d = pend_ftw_q;
        pending_d  = pending_q;

        if (SYNC_CLR) begin
            acc_d = '0;
        end else if (EN) begin
            acc_d  = sum[PHASE_WIDTH-1:0];
            wrap_d = carry;
        end

        unique case (apply_cause)
            ApplyWrap, ApplyIdle, ApplyClr: begin
                ftw_d     = pend_ftw_q;
                pending_d = 1'b0;
            end
            default: ;
        endcase

        if (accept) begin
            pend_ftw_d = FTW_IN;
            pending_d  = 1'b1;
        end
    end

    // State registers; reset discards any held tuning word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q      <= '0;
            ftw_q      <= '0;
            pend_ftw_q <= '0;
            pending_q  <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            ftw_q      <= ftw_d;
            pend_ftw_q <= pend_ftw_d;
            pending_q  <= pending_d;
            wrap_q     <= wrap_d;
        end
    end

    assign FTW_READY  = !pending_q;
    assign PHASE_ADDR = acc_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
    assign WRAP       = wrap_q;

endmodule

// File: rtl/dds_phase_reader.sv
// DDS table read master: drives the RAM read address from the accumulator
// phase plus an offset, and realigns the registered RAM output with a
// valid flag (address cycle -> RAM register -> SAMPLE register).
module dds_phase_reader
    import dds_pkg::*;
#(
    parameter int unsigned PHASE_WIDTH = DEF_PHASE_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   EN,
    input  logic                   SYNC_CLR,
    input  logic [PHASE_WIDTH-1:0] FTW_IN,
    input  logic                   FTW_VALID,
    output logic                   FTW_READY,
    input  logic [ADDR_WIDTH-1:0]  PHASE_OFFSET,
    output logic [ADDR_WIDTH-1:0]  RD_ADDR,
    input  logic [DATA_WIDTH-1:0]  RAM_DOUT,
    output logic [DATA_WIDTH-1:0]  SAMPLE,
    output logic                   SAMPLE_VALID,
    output logic                   WRAP
);

    logic [ADDR_WIDTH-1:0] phase_addr;
    logic                  v1_q, v1_d;
    logic [DATA_WIDTH-1:0] sample_q, sample_d;
    logic                  sample_valid_q, sample_valid_d;

    dds_phase_acc #(
        .PHASE_WIDTH (PHASE_WIDTH),
        .ADDR_WIDTH  (ADDR_WIDTH)
    ) u_phase_acc (
        .CLK        (CLK),
        .RST        (RST),
        .EN         (EN),
        .SYNC_CLR   (SYNC_CLR),
        .FTW_IN     (FTW_IN),
        .FTW_VALID  (FTW_VALID),
        .FTW_READY  (FTW_READY),
        .PHASE_ADDR (phase_addr),
        .WRAP       (WRAP)
    );

    // Offset add wraps naturally modulo the table size.
    assign RD_ADDR = phase_addr + PHASE_OFFSET;

    // Pipeline next-state: v1 marks that the RAM captured a wanted address.
    always_comb begin
        v1_d           = EN && !SYNC_CLR;
        sample_d       = sample_q;
        sample_valid_d = 1'b0;
        if (v1_q) begin
            sample_d       = RAM_DOUT;
            sample_valid_d = 1'b1;
        end
    end

    // Pipeline registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1_q           <= 1'b0;
            sample_q       <= '0;
            sample_valid_q <= 1'b0;
        end else begin
            v1_q           <= v1_d;
            sample_q       <= sample_d;
            sample_valid_q <= sample_valid_d;
        end
    end

    assign SAMPLE       = sample_q;
    assign SAMPLE_VALID = sample_valid_q;

endmodule

// File: tb/tb_dds_phase_reader.sv
// Scoreboard bench for dds_phase_reader with a registered-read RAM model.
module tb_dds_phase_reader;

    localparam int unsigned PW = 24;
    localparam int unsigned AW = 8;
    localparam int unsigned DW = 6;

    logic          CLK;
    logic          RST;
    logic          EN;
    logic          SYNC_CLR;
    logic [PW-1:0] FTW_IN;
    logic          FTW_VALID;
    logic          FTW_READY;
    logic [AW-1:0] PHASE_OFFSET;
    logic [AW-1:0] RD_ADDR;
    logic [DW-1:0] RAM_DOUT;
    logic [DW-1:0] SAMPLE;
    logic          SAMPLE_VALID;
    logic          WRAP;

    dds_phase_reader #(
        .PHASE_WIDTH (PW),
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .EN           (EN),
        .SYNC_CLR     (SYNC_CLR),
        .FTW_IN       (FTW_IN),
        .FTW_VALID    (FTW_VALID),
        .FTW_READY    (FTW_READY),
        .PHASE_OFFSET (PHASE_OFFSET),
        .RD_ADDR      (RD_ADDR),
        .RAM_DOUT     (RAM_DOUT),
        .SAMPLE       (SAMPLE),
        .SAMPLE_VALID (SAMPLE_VALID),
        .WRAP         (WRAP)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Waveform table with one-cycle registered read.
    logic [DW-1:0] mem [256];
    always @(posedge CLK) RAM_DOUT <= mem[RD_ADDR];

    int unsigned edge_cnt = 0;
    always @(posedge CLK) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int unsigned   due;
        logic [DW-1:0] val;
    } exp_t;
    exp_t q[$];

    // Reference model state (phase as a plain integer).
    longint unsigned m_phase, m_ftw, m_pend_ftw;
    bit              m_pend, m_wrap;
    logic [DW-1:0]   last_sample;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_ftw = 0; m_pend_ftw = 0; m_pend = 0; m_wrap = 0;
        last_sample = '0;
        q.delete();
    endtask

    // One clock: drive at negedge, check address/ready, predict, advance.
    task automatic step(input bit en, input bit clr, input bit fv, input logic [PW-1:0] fin);
        longint unsigned sum;
        bit              carry, apply, accept;
        logic [AW-1:0]   a;
        exp_t            e;
        EN = en; SYNC_CLR = clr; FTW_VALID = fv; FTW_IN = fin;
        #1;
        a = AW'(((m_phase >> (PW - AW)) + longint'(PHASE_OFFSET)) % 256);
        chk("rd_addr", RD_ADDR, a);
        chk("ftw_ready", FTW_READY, !m_pend);
        if (en && !clr) begin
            e.due = edge_cnt + 2;
            e.val = mem[a];
            q.push_back(e);
        end
        accept = fv && !m_pend;
        sum    = m_phase + m_ftw;
        carry  = sum >= (64'd1 << PW);
        if (clr) begin
            apply = m_pend; m_phase = 0; m_wrap = 0;
        end else if (en) begin
            apply = m_pend && carry; m_phase = sum % (64'd1 << PW); m_wrap = carry;
        end else begin
            apply = m_pend; m_wrap = 0;
        end
        if (apply) begin m_ftw = m_pend_ftw; m_pend = 0; end
        if (accept) begin m_pend_ftw = fin; m_pend = 1; end
        @(posedge CLK);
        @(negedge CLK);
        chk("wrap", WRAP, m_wrap);
    endtask

    // Monitor: pops an expectation whenever the DUT presents a sample.
    always @(posedge CLK) begin
        exp_t e;
        #1;
        if (!RST) begin
            if (SAMPLE_VALID) begin
                if (q.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sample_time", edge_cnt, e.due);
                    chk("sample_val", SAMPLE, e.val);
                    last_sample = e.val;
                end
            end else begin
                chk("sample_hold", SAMPLE, last_sample);
                if (q.size() > 0 && q[0].due <= edge_cnt) begin
                    chk("missing_sample", 0, 1);
                    void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = DW'(i % 64);
        model_reset();
        RST = 1; EN = 0; SYNC_CLR = 0; FTW_VALID = 0; FTW_IN = '0; PHASE_OFFSET = '0;
        #2;
        chk("rst_sample", SAMPLE, 0);
        chk("rst_valid", SAMPLE_VALID, 0);
        chk("rst_wrap", WRAP, 0);
        chk("rst_ready", FTW_READY, 1);
        @(negedge CLK); @(negedge CLK);
        RST = 0;

        // Load 0x010000 while stalled, then ramp through a full lap.
        step(0, 0, 1, 24'h010000);
        step(0, 0, 0, '0);
        for (int i = 0; i < 272; i++) step(1, 0, 0, '0);
        // acc now 0x100000: offer a new word mid-lap; it waits for the wrap.
        step(1, 0, 1, 24'h020000);
        for (int i = 0; i < 260; i++) step(1, 0, 0, '0);
        chk("ftw_applied", m_ftw, 24'h020000);

        // Offset check at top byte 0xF0.
        for (int i = 0; i < 200 && (m_phase >> 16) != 64'hF0; i++) step(1, 0, 0, '0);
        PHASE_OFFSET = 8'h40;
        #1;
        chk("offset_f0", RD_ADDR, 8'h30);
        for (int i = 0; i < 10; i++) step(1, 0, 0, '0);
        step(1, 1, 0, '0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, '0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, '0);

        // Drain, then randomise table contents and stimulus.
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0);
        for (int i = 0; i < 256; i++) mem[i] = DW'($urandom);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) PHASE_OFFSET = AW'($urandom);
            step($urandom_range(0, 9) != 0, $urandom_range(0, 29) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 1) ? PW'($urandom) : PW'($urandom_range(0, 1 << 20)));
        end

        // Async reset with a word pending.
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0);
        step(0, 0, 1, 24'h000100);
        step(0, 0, 0, '0);
        step(1, 0, 1, 24'hABCDEF);
        step(1, 0, 0, '0);
        @(posedge CLK);
        #2;
        RST = 1;
        #1;
        model_reset();
        chk("arst_sample", SAMPLE, 0);
        chk("arst_valid", SAMPLE_VALID, 0);
        chk("arst_wrap", WRAP, 0);
        chk("arst_ready", FTW_READY, 1);
        @(negedge CLK);
        RST = 0;
        for (int i = 0; i < 12; i++) step(1, 0, 0, '0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
